// File: rtl/mmips_mem_pkg.sv
// Shared types and default geometry for the DataMemory arbiter slice.
package mmips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int DEF_NUM_REQ   = 2;
    localparam int DEF_ADDR_W    = 8;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_MEM_DEPTH = 32;

    function automatic int next_idx(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/data_memory_arbiter_rr.sv
// Combinational round-robin pick: first asserted request at or after rr_ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] win_onehot,
    output logic [IDX_W-1:0]   win_idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        win_onehot = '0;
        win_idx    = '0;
        found      = 1'b0;
        cand       = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = IDX_W'((int'(rr_ptr) + off) % NUM_REQ);
            if (!found && req[cand]) begin
                win_onehot[cand] = 1'b1;
                win_idx          = cand;
                found            = 1'b1;
            end
        end
    end

endmodule

// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter sharing the single-ported DataMemory; one access per 3-cycle
// IDLE -> ACCESS -> RESP round trip, out-of-range addresses blocked and flagged.
module data_memory_arbiter
    import mmips_mem_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MEM_DEPTH = DEF_MEM_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [NUM_REQ-1:0]         rvalid,
    output logic [DATA_W-1:0]          rdata,
    output logic                       err,
    output logic [ADDR_W-1:0]          mem_address,
    output logic [DATA_W-1:0]          mem_write_data,
    output logic                       mem_write_sig,
    input  logic [DATA_W-1:0]          mem_read_data
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(MEM_DEPTH);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, idx_q, win_idx;
    logic [NUM_REQ-1:0] win_onehot;
    logic               win_any;
    logic               we_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [DATA_W-1:0]  rdata_q;
    logic               err_q;
    logic               in_range;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req        (req),
        .rr_ptr     (rr_ptr_q),
        .win_onehot (win_onehot),
        .win_idx    (win_idx)
    );

    assign win_any  = |win_onehot;
    assign in_range = {1'b0, addr_q} < DEPTH_L;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_any) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control state: reset asynchronously so a pending write is dropped at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            idx_q    <= '0;
            we_q     <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (win_any) begin
                        idx_q <= win_idx;
                        we_q  <= req_we[win_idx];
                    end
                end
                ACCESS: begin
                    rdata_q <= (in_range && !we_q) ? mem_read_data : '0;
                    err_q   <= ~in_range;
                end
                RESP: begin
                    rr_ptr_q <= IDX_W'(next_idx(int'(idx_q), NUM_REQ));
                end
                default: ;
            endcase
        end
    end

    // Address/write-data latches need no reset; they are only observed in ACCESS.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && win_any) begin
            addr_q  <= req_addr[win_idx*ADDR_W +: ADDR_W];
            wdata_q <= req_wdata[win_idx*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        gnt            = '0;
        rvalid         = '0;
        rdata          = '0;
        err            = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        mem_write_sig  = 1'b0;
        case (state_q)
            ACCESS: begin
                gnt[idx_q]     = 1'b1;
                mem_address    = addr_q;
                mem_write_data = wdata_q;
                mem_write_sig  = we_q & in_range;
            end
            RESP: begin
                rvalid[idx_q] = 1'b1;
                rdata         = rdata_q;
                err           = err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench: arbiter in front of a 32-word DataMemory model with combinational read.
module tb_data_memory_arbiter;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 8;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]         rdata;
    logic                      err;
    logic [ADDR_W-1:0]         mem_address;
    logic [DATA_W-1:0]         mem_write_data;
    logic                      mem_write_sig;
    logic [DATA_W-1:0]         mem_read_data;

    logic                      ld_en;
    logic [4:0]                ld_addr;
    logic [7:0]                ld_data;
    logic [7:0]                mem     [0:31];
    logic [7:0]                exp_mem [0:31];

    int tests = 0;
    int fails = 0;

    data_memory_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MEM_DEPTH (32)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req            (req),
        .req_we         (req_we),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .gnt            (gnt),
        .rvalid         (rvalid),
        .rdata          (rdata),
        .err            (err),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_write_sig  (mem_write_sig),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;

    // Address bits above [4:0] alias, so a leaked out-of-range write would corrupt a word.
    assign mem_read_data = mem[mem_address[4:0]];
    always @(posedge clk) begin
        if (ld_en)
            mem[ld_addr] <= ld_data;
        else if (mem_write_sig)
            mem[mem_address[4:0]] <= mem_write_data;
    end

    function automatic logic [7:0] img(input int i);
        return (i == 8) ? 8'h00 : 8'(i * 37 + 11);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input bit p, input bit we, input logic [7:0] addr, input logic [7:0] wd);
        req[p]             = 1'b1;
        req_we[p]          = we;
        req_addr[p*8 +: 8]  = addr;
        req_wdata[p*8 +: 8] = wd;
    endtask

    // Entered at a negedge with the FSM in IDLE; leaves at the IDLE negedge after RESP.
    task automatic do_access(input bit p, input bit we, input logic [7:0] addr,
                             input logic [7:0] wd, input logic [7:0] exp_rd,
                             input bit exp_err, input string tag);
        logic [1:0] oh;
        bit         commit;
        oh     = 2'b01 << p;
        commit = we && (addr < 8'd32);
        set_req(p, we, addr, wd);
        @(negedge clk);
        check({tag, "_gnt"}, 32'(gnt), 32'(oh));
        check({tag, "_addr"}, 32'(mem_address), 32'(addr));
        check({tag, "_we"}, 32'(mem_write_sig), 32'(commit));
        check({tag, "_norv"}, 32'(rvalid), 0);
        req[p] = 1'b0;
        @(negedge clk);
        check({tag, "_rv"}, 32'(rvalid), 32'(oh));
        check({tag, "_gnt0"}, 32'(gnt), 0);
        check({tag, "_rdata"}, 32'(rdata), 32'(exp_rd));
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        if (commit) exp_mem[addr[4:0]] = wd;
        @(negedge clk);
        check({tag, "_idle"}, 32'({gnt, rvalid}), 0);
    endtask

    initial begin
        int bad;
        int rv_cnt;
        int ph;
        int port;
        logic [1:0] oh;

        rst_n     = 1'b0;
        req       = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        ld_en     = 1'b0;
        ld_addr   = '0;
        ld_data   = '0;

        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            ld_en      = 1'b1;
            ld_addr    = 5'(i);
            ld_data    = img(i);
            exp_mem[i] = img(i);
        end
        @(negedge clk);
        ld_en = 1'b0;
        check("rst_gnt", 32'(gnt), 0);
        check("rst_rvalid", 32'(rvalid), 0);
        check("rst_rdata_err", 32'({rdata, err}), 0);
        check("rst_mem_pins", 32'({mem_address, mem_write_data, mem_write_sig}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset in the middle of ACCESS must abort the write.
        set_req(1'b0, 1'b1, 8'd3, 8'h55);
        @(negedge clk);
        check("abort_gnt", 32'(gnt), 32'h1);
        check("abort_we_before", 32'(mem_write_sig), 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_we_after", 32'(mem_write_sig), 0);
        check("abort_outs", 32'({gnt, rvalid, rdata, err, mem_address}), 0);
        req[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_mem3", 32'(mem[3]), 32'(img(3)));
        @(negedge clk);
        check("abort_idle", 32'({gnt, rvalid}), 0);

        do_access(1'b0, 1'b1, 8'd5, 8'hA5, 8'h00, 1'b0, "wr5");
        check("wr5_mem", 32'(mem[5]), 32'hA5);
        do_access(1'b0, 1'b0, 8'd5, 8'h00, 8'hA5, 1'b0, "rd5");

        do_access(1'b1, 1'b1, 8'd40, 8'hFF, 8'h00, 1'b1, "oor");
        bad = 0;
        for (int i = 0; i < 32; i++) if (mem[i] !== exp_mem[i]) bad++;
        check("oor_mem_intact", 32'(bad), 0);
        do_access(1'b1, 1'b0, 8'd8, 8'h00, 8'h00, 1'b0, "rd8");

        // Both ports held: expect strict alternation starting at port 0.
        set_req(1'b0, 1'b0, 8'd5, 8'h00);
        set_req(1'b1, 1'b0, 8'd10, 8'h00);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            ph   = (k - 1) % 3;
            port = ((k - 1) / 3) % 2;
            oh   = 2'b01 << port;
            check("rr_gnt", 32'(gnt), (ph == 0) ? 32'(oh) : 0);
            check("rr_rvalid", 32'(rvalid), (ph == 1) ? 32'(oh) : 0);
            if (ph == 1)
                check("rr_rdata", 32'(rdata), 32'(exp_mem[port == 0 ? 5 : 10]));
            if (k == 11) req = '0;
        end
        @(negedge clk);
        check("rr_stop", 32'({gnt, rvalid}), 0);

        // req0 raised during a port-1 access and dropped before IDLE is never granted.
        set_req(1'b1, 1'b0, 8'd10, 8'h00);
        @(negedge clk);
        check("wd_gnt1", 32'(gnt), 32'h2);
        req[1] = 1'b0;
        set_req(1'b0, 1'b0, 8'd7, 8'h00);
        @(negedge clk);
        check("wd_rv1", 32'(rvalid), 32'h2);
        check("wd_rdata", 32'(rdata), 32'(exp_mem[10]));
        req[0] = 1'b0;
        @(negedge clk);
        check("wd_idle_a", 32'({gnt, rvalid}), 0);
        @(negedge clk);
        check("wd_idle_b", 32'({gnt, rvalid}), 0);
        do_access(1'b1, 1'b0, 8'd12, 8'h00, exp_mem[12], 1'b0, "wd_req1");

        // Port 0 streams reads of the whole image, one every 3 cycles.
        rv_cnt = 0;
        set_req(1'b0, 1'b0, 8'd0, 8'h00);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            check("b2b_gnt", 32'(gnt), 32'h1);
            if (i < 31) req_addr[7:0] = 8'(i + 1);
            else req[0] = 1'b0;
            @(negedge clk);
            if (rvalid == 2'b01) rv_cnt++;
            check("b2b_rdata", 32'(rdata), 32'(exp_mem[i]));
            @(negedge clk);
            check("b2b_idle", 32'({gnt, rvalid}), 0);
        end
        check("b2b_count", 32'(rv_cnt), 32);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
